// File: rtl/rr_arb_mux.sv
// rr_arb_mux: M-channel arbitrated selector with a one-entry registered output.
// Optional build macro RRMUX_FORCE_SEL_EN adds force_en/force_sel grant override.
module rr_arb_mux #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int SW = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  input  logic            mode,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef RRMUX_FORCE_SEL_EN
  input  logic            force_en,
  input  logic [SW-1:0]   force_sel,
`endif
  output logic [SW-1:0]   out_sel
);

  logic [SW-1:0] r_ptr;
  logic [N-1:0]  r_data;
  logic [SW-1:0] r_sel;
  logic          r_valid;

  logic [SW-1:0] w_gnt;
  logic [SW-1:0] w_idx;
  logic          w_any;
  logic          w_force;
  logic          w_load;
  logic          w_xfer;

  assign w_load = !r_valid || out_ready;

  // Searches run high-to-low so the last hit is the highest priority.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    w_force = 1'b0;
    if (mode) begin
      for (int k = M; k >= 1; k--) begin
        w_idx = SW'((int'(r_ptr) + k) % M);
        if (in_valid[w_idx]) begin
          w_gnt = w_idx;
          w_any = 1'b1;
        end
      end
    end else begin
      for (int i = M - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          w_gnt = SW'(i);
          w_any = 1'b1;
        end
      end
    end
`ifdef RRMUX_FORCE_SEL_EN
    if (force_en) begin
      w_force = 1'b1;
      w_gnt   = force_sel;
      w_any   = (int'(force_sel) < M) && in_valid[force_sel];
    end
`endif
  end

  assign w_xfer   = w_load && w_any && !rst;
  assign in_ready = w_xfer ? (M'(1) << w_gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= SW'(M - 1);
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= in_data[int'(w_gnt)*N +: N];
      r_sel   <= w_gnt;
      r_valid <= 1'b1;
      if (mode && !w_force) r_ptr <= w_gnt;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed and random checks of rr_arb_mux
// against a behavioural arbitration model.
module tb_rr_arb_mux;
  localparam int N  = 32;
  localparam int M  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic           mode;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;
`ifdef RRMUX_FORCE_SEL_EN
  logic           force_en;
  logic [SW-1:0]  force_sel;
`endif

  int vectors = 0;
  int miscompares = 0;

  int          m_ptr;
  bit          m_valid;
  logic [N-1:0] m_data;
  int          m_sel;

  always #5 clk = ~clk;

  rr_arb_mux #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RRMUX_FORCE_SEL_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .out_sel   (out_sel)
  );

  function automatic bit forcing();
`ifdef RRMUX_FORCE_SEL_EN
    return force_en;
`else
    return 1'b0;
`endif
  endfunction

  // Expected winner this cycle, -1 when nothing transfers.
  function automatic int exp_grant();
    bit load;
    load = !m_valid || out_ready;
    if (rst || !load) return -1;
`ifdef RRMUX_FORCE_SEL_EN
    if (force_en) begin
      if (int'(force_sel) < M && in_valid[force_sel]) return int'(force_sel);
      return -1;
    end
`endif
    if (!mode) begin
      for (int i = 0; i < M; i++) if (in_valid[i]) return i;
    end else begin
      for (int k = 1; k <= M; k++)
        if (in_valid[(m_ptr + k) % M]) return (m_ptr + k) % M;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs,
                     input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = M - 1;
    m_valid = 1'b0;
    m_data = '0;
    m_sel = 0;
  endtask

  task automatic cycle();
    int g;
    logic [M-1:0] er;
    @(negedge clk);
    g = exp_grant();
    er = (g < 0) ? '0 : (M'(1) << g);
    chk("in_ready", N'(in_ready), N'(er));
    chk("out_valid", N'(out_valid), N'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_sel", N'(out_sel), N'(m_sel));
    @(posedge clk);
    if (rst) model_reset();
    else if (g >= 0) begin
      m_data = in_data[g*N +: N];
      m_sel = g;
      m_valid = 1'b1;
      if (mode && !forcing()) m_ptr = g;
    end else if (m_valid && out_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < M; i++) in_data[i*N +: N] = N'(32'h11111111 * i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '1;
    mode = 1'b1;
    out_ready = 1'b1;
`ifdef RRMUX_FORCE_SEL_EN
    force_en = 1'b0;
    force_sel = '0;
`endif
    set_ramp();
    @(posedge clk);
    model_reset();
    #1;
    do_reset();

    // Wrap from ptr=M-1 then back-pressure.
    mode = 1'b1;
    in_valid = 4'b0101;
    cycle();
    chk("first_rr_sel", N'(out_sel), 0);
    out_ready = 1'b0;
    repeat (3) cycle();
    chk("hold_data", out_data, 32'h0);
    out_ready = 1'b1;
    cycle();
    chk("after_bp_sel", N'(out_sel), 2);

    // Fixed priority.
    do_reset();
    mode = 1'b0;
    in_valid = 4'b1010;
    repeat (3) begin
      cycle();
      chk("fp_data", out_data, 32'h11111111);
    end

    // Round-robin fairness from reset.
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_seq", N'(out_sel), N'(k % M));
    end

    // Simultaneous in/out transfer, no bubble.
    in_valid = 4'b0100;
    cycle();
    chk("sim_valid", N'(out_valid), 1);
    chk("sim_data", out_data, 32'h22222222);

`ifdef RRMUX_FORCE_SEL_EN
    force_en = 1'b1;
    force_sel = 2'd2;
    in_valid = 4'b1111;
    repeat (3) begin
      cycle();
      chk("force_sel", N'(out_sel), 2);
    end
    force_en = 1'b0;
    cycle();
    chk("force_resume", N'(out_sel), 3);
`endif

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      in_valid = M'($urandom);
      mode = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < M; i++) in_data[i*N +: N] = $urandom;
`ifdef RRMUX_FORCE_SEL_EN
      force_en = ($urandom_range(0, 7) == 0);
      force_sel = SW'($urandom);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
